// File: rtl/imem_axil_rd_slave.sv
// -----------------------------------------------------------------------------
// imem_axil_rd_slave
//
// AXI-lite read-channel responder for instruction fetch. It accepts an AR
// request, looks up the 64-bit doubleword that holds the byte address, and
// returns it on the R channel after LATENCY extra wait cycles. Addresses
// outside [BASE_ADDR, BASE_ADDR + DEPTH*8) return zero data with SLVERR.
//
// Optional feature macro: IMEM_B2B_EN
//   Defined   : a new AR is accepted in the same cycle the R beat is taken,
//               so back-to-back fetches skip IDLE (1 beat/cycle at LATENCY=0).
//   Undefined : ARREADY is only high in IDLE.
//
// Ports:
//   clk      in   1       clock, rising edge
//   rst      in   1       asynchronous active-low reset
//   ARVALID  in   1       read address valid
//   ARADDR   in   ADDR_W  byte address
//   ARREADY  out  1       slave can accept an address
//   RVALID   out  1       read data valid
//   RDATA    out  DATA_W  aligned doubleword
//   RRESP    out  2       2'b00 OKAY, 2'b10 SLVERR
//   RREADY   in   1       master accepts data
// -----------------------------------------------------------------------------
module imem_axil_rd_slave #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 64,
   parameter int                DEPTH     = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter int                LATENCY   = 1,
   parameter string             INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ARVALID,
   input  logic [ADDR_W-1:0] ARADDR,
   output logic              ARREADY,
   output logic              RVALID,
   output logic [DATA_W-1:0] RDATA,
   output logic [1:0]        RRESP,
   input  logic              RREADY
);

   localparam int              IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Size of the mapped window in bytes, one bit wider than the address so
   // the range check cannot overflow at the top of the address space.
   localparam logic [ADDR_W:0] SPAN   = (ADDR_W + 1)'(DEPTH) << 3;
   localparam logic [3:0]      LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [3:0]          r_cnt;
   logic [DATA_W-1:0]   r_rdata;
   logic [1:0]          r_rresp;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_accept;
   logic                w_ar_hs;
   logic [ADDR_W-1:0]   w_ld_addr;
   logic [ADDR_W:0]     w_off;
   logic                w_in_range;
   logic [IDX_W-1:0]    w_idx;
   logic [DATA_W-1:0]   w_ld_data;
   logic [1:0]          w_ld_resp;

   // Acceptance window without the reset term; ARREADY adds the reset mask.
`ifdef IMEM_B2B_EN
   assign w_accept = (r_state == ST_IDLE) || ((r_state == ST_RESP) && RREADY);
`else
   assign w_accept = (r_state == ST_IDLE);
`endif

   assign ARREADY = rst && w_accept;
   assign w_ar_hs = ARVALID && w_accept;
   assign RVALID  = (r_state == ST_RESP);
   assign RDATA   = r_rdata;
   assign RRESP   = r_rresp;

   // Data is loaded on entry to RESP: from the live AR address when there is
   // no wait stage, otherwise from the latched address at the end of WAIT.
   assign w_ld_addr  = (r_state == ST_WAIT) ? r_addr : ARADDR;
   assign w_off      = {1'b0, w_ld_addr} - {1'b0, BASE_ADDR};
   assign w_in_range = ({1'b0, w_ld_addr} >= {1'b0, BASE_ADDR}) && (w_off < SPAN);
   // Bits [2:0] select a byte inside the doubleword and are dropped here.
   assign w_idx      = w_off[IDX_W+2:3];
   assign w_ld_data  = w_in_range ? r_mem[w_idx] : '0;
   assign w_ld_resp  = w_in_range ? RESP_OKAY : RESP_SLVERR;

   // NOTE: the memory array is deliberately left out of the reset branch;
   // resetting it would force a flop-per-bit implementation instead of RAM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         // New request, from IDLE or (back-to-back) from RESP with RREADY.
         r_addr <= ARADDR;
         if (LATENCY == 0) begin
            r_state <= ST_RESP;
            r_rdata <= w_ld_data;
            r_rresp <= w_ld_resp;
         end else begin
            r_state <= ST_WAIT;
            r_cnt   <= LAT_M1;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_IDLE;
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_RESP;
                  r_rdata <= w_ld_data;
                  r_rresp <= w_ld_resp;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               // Data and response hold while the master stalls.
               if (RREADY) r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_axil_rd_slave.sv
// -----------------------------------------------------------------------------
// tb_imem_axil_rd_slave
//
// Directed bench for imem_axil_rd_slave. The main instance runs with
// LATENCY=1; a second instance with LATENCY=0 covers streaming throughput,
// whose expected beat pattern depends on IMEM_B2B_EN.
// -----------------------------------------------------------------------------
module tb_imem_axil_rd_slave;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam logic [63:0] W0   = 64'h0000_0413_0000_0297;
   localparam logic [63:0] W1   = 64'h1111_2222_3333_4444;
   localparam logic [63:0] W2   = 64'h5555_6666_7777_8888;
   localparam logic [63:0] WL   = 64'hDEAD_BEEF_CAFE_F00D;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] araddr;
   logic [63:0] rdata;
   logic [1:0]  rresp;

   logic        arvalid_z, arready_z, rvalid_z, rready_z;
   logic [31:0] araddr_z;
   logic [63:0] rdata_z;
   logic [1:0]  rresp_z;

   int n_tests = 0;
   int n_fail  = 0;

   imem_axil_rd_slave #(.LATENCY(1)) dut (
      .clk     (clk),
      .rst     (rst),
      .ARVALID (arvalid),
      .ARADDR  (araddr),
      .ARREADY (arready),
      .RVALID  (rvalid),
      .RDATA   (rdata),
      .RRESP   (rresp),
      .RREADY  (rready)
   );

   imem_axil_rd_slave #(.LATENCY(0)) dut_z (
      .clk     (clk),
      .rst     (rst),
      .ARVALID (arvalid_z),
      .ARADDR  (araddr_z),
      .ARREADY (arready_z),
      .RVALID  (rvalid_z),
      .RDATA   (rdata_z),
      .RRESP   (rresp_z),
      .RREADY  (rready_z)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full read on the LATENCY=1 instance with RREADY held high.
   task automatic do_read(input string tag, input logic [31:0] addr,
                          input logic [63:0] exp_d, input logic [1:0] exp_r);
      check({tag, " arready idle"}, 64'(arready), 64'd1);
      arvalid = 1'b1;
      araddr  = addr;
      tick();
      arvalid = 1'b0;
      check({tag, " rvalid in wait"}, 64'(rvalid), 64'd0);
      tick();
      check({tag, " rvalid"}, 64'(rvalid), 64'd1);
      check({tag, " rdata"},  rdata, exp_d);
      check({tag, " rresp"},  64'(rresp), 64'(exp_r));
      tick();
      check({tag, " rvalid clear"}, 64'(rvalid), 64'd0);
      check({tag, " arready back"}, 64'(arready), 64'd1);
   endtask

   logic [31:0] addrs [3];
   bit          exp_v [6];
   logic [63:0] exp_d [6];
   int          k;
   bit          hs;

   initial begin
      rst       = 1'b0;
      arvalid   = 1'b0;
      araddr    = '0;
      rready    = 1'b1;
      arvalid_z = 1'b0;
      araddr_z  = '0;
      rready_z  = 1'b0;

      dut.r_mem[0]    = W0;
      dut.r_mem[1]    = W1;
      dut.r_mem[2]    = W2;
      dut.r_mem[4095] = WL;
      dut_z.r_mem[0]  = W0;
      dut_z.r_mem[1]  = W1;
      dut_z.r_mem[2]  = W2;

      // Reset state
      tick();
      tick();
      check("rst arready", 64'(arready), 64'd0);
      check("rst rvalid",  64'(rvalid),  64'd0);
      check("rst rdata",   rdata,        64'd0);
      check("rst rresp",   64'(rresp),   64'd0);
      rst = 1'b1;
      #1;
      check("post-rst arready", 64'(arready), 64'd1);
      tick();

      // Decode: aligned, ignored low bits, next word, boundaries
      do_read("w0",        BASE,              W0,    2'b00);
      do_read("w0 +4",     BASE + 32'h4,      W0,    2'b00);
      do_read("w1",        BASE + 32'h8,      W1,    2'b00);
      do_read("above top", 32'h8000_8000,     64'd0, 2'b10);
      do_read("below base",32'h7FFF_FFF8,     64'd0, 2'b10);
      do_read("last word", 32'h8000_7FF8,     WL,    2'b00);
      do_read("addr max",  32'hFFFF_FFF8,     64'd0, 2'b10);

      // Backpressure: response must hold while RREADY is low
      rready  = 1'b0;
      arvalid = 1'b1;
      araddr  = BASE + 32'h10;
      tick();
      arvalid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp rvalid",  64'(rvalid),  64'd1);
         check("bp rdata",   rdata,        W2);
         check("bp rresp",   64'(rresp),   64'd0);
         check("bp arready", 64'(arready), 64'd0);
         tick();
      end
      rready = 1'b1;
      tick();
      check("bp release rvalid",  64'(rvalid),  64'd0);
      check("bp release arready", 64'(arready), 64'd1);

      // Reset during WAIT: nothing surfaces afterwards
      arvalid = 1'b1;
      araddr  = BASE;
      tick();
      arvalid = 1'b0;
      rst = 1'b0;
      #1;
      check("rst wait rvalid",  64'(rvalid),  64'd0);
      check("rst wait arready", 64'(arready), 64'd0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("no stale rvalid", 64'(rvalid), 64'd0);
      end

      // Reset during RESP: RVALID drops asynchronously
      rready  = 1'b0;
      arvalid = 1'b1;
      araddr  = BASE + 32'h8;
      tick();
      arvalid = 1'b0;
      tick();
      check("pre-rst resp rvalid", 64'(rvalid), 64'd1);
      rst = 1'b0;
      #1;
      check("rst resp rvalid", 64'(rvalid), 64'd0);
      check("rst resp rdata",  rdata,       64'd0);
      tick();
      rst    = 1'b1;
      rready = 1'b1;
      tick();
      check("after rst rvalid", 64'(rvalid), 64'd0);
      do_read("recover", BASE + 32'h8, W1, 2'b00);

      // Streaming on the LATENCY=0 instance
      addrs = '{BASE, BASE + 32'h8, BASE + 32'h10};
`ifdef IMEM_B2B_EN
      exp_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_d = '{W0, W1, W2, 64'd0, 64'd0, 64'd0};
`else
      exp_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_d = '{W0, 64'd0, W1, 64'd0, W2, 64'd0};
`endif
      k         = 0;
      rready_z  = 1'b1;
      arvalid_z = 1'b1;
      araddr_z  = addrs[0];
      #1;
      hs = arvalid_z && arready_z;
      for (int n = 0; n < 6; n++) begin
         tick();
         check($sformatf("stream rvalid %0d", n), 64'(rvalid_z), 64'(exp_v[n]));
         if (exp_v[n]) begin
            check($sformatf("stream rdata %0d", n), rdata_z, exp_d[n]);
            check($sformatf("stream rresp %0d", n), 64'(rresp_z), 64'd0);
         end
         if (hs) k++;
         arvalid_z = (k < 3);
         araddr_z  = (k < 3) ? addrs[k] : 32'd0;
         #1;
         hs = arvalid_z && arready_z;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
